// File: rtl/stream_check_pkg.sv
// Shared types and helpers for the stream checker.
package stream_check_pkg;

  // Checker phases: live traffic, draining after flush, final verdict.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Reasons err_cnt can advance; used as bit positions in a per-cycle flag vector.
  typedef enum logic [1:0] {
    ERR_MISMATCH  = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_cause_e;

  localparam int unsigned NUM_ERR_CAUSES = 4;

  // Unsigned add clamped to max_val; the 33-bit sum keeps the carry visible.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/stream_check_fifo.sv
// Synchronous FIFO holding expected words; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module stream_check_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Advance read/write pointers on accepted operations.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Write storage on accepted push.
  // NOTE: storage is deliberately not reset; empty pointers make stale
  // contents unreachable, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == (AW+1)'(DEPTH));

endmodule

// File: rtl/stream_checker.sv
// Receive-side stream checker: queues expected words (raw + OFFSET), compares
// each actual word in order, counts matches/errors and gives a final verdict
// after a bounded drain phase.
module stream_checker
  import stream_check_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          DEPTH   = 16,
  parameter int unsigned OFFSET  = 1,
  parameter int          CNT_W   = 16,
  parameter int          TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             act_valid,
  input  logic [WIDTH-1:0] act_data,
  input  logic             flush,
  output logic             exp_full,
  output logic             cmp_valid,
  output logic             cmp_match,
  output logic [WIDTH-1:0] cmp_got,
  output logic [WIDTH-1:0] cmp_exp,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             done,
  output logic             pass
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_e                    state_q, state_d;
  logic                      active;
  logic                      in_drain;

  logic [WIDTH-1:0]          fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AW:0]               fifo_count;

  logic                      push_req, pop_req;
  logic                      push_ok, pop_ok;
  logic                      words_equal;
  logic                      drain_idle;
  logic                      timer_expired;
  logic [TMR_W-1:0]          timer_q;

  logic [NUM_ERR_CAUSES-1:0] err_flags;
  logic [31:0]               remaining;
  logic [31:0]               err_inc;
  logic                      match_inc;

  logic [CNT_W-1:0]          match_q, err_q;
  logic                      cmp_valid_q, cmp_match_q;
  logic [WIDTH-1:0]          cmp_got_q, cmp_exp_q;

  // Traffic is only accepted before the verdict; DONE freezes everything.
  assign push_req    = exp_valid & active;
  assign pop_req     = act_valid & active;
  assign push_ok     = push_req & ~fifo_full;
  assign pop_ok      = pop_req & ~fifo_empty;
  assign words_equal = (act_data == fifo_head);

  stream_check_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req),
    .push_data_i (exp_data + WIDTH'(OFFSET)),
    .pop_i       (pop_req),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Drain ends cleanly when nothing is queued and no traffic arrives this
  // cycle; otherwise the last timer cycle forces the verdict.
  assign drain_idle    = fifo_empty & ~push_req & ~pop_req;
  assign timer_expired = in_drain & (timer_q == TMR_W'(TIMEOUT - 1)) & ~drain_idle;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next-state logic; flush outside RUN has no effect.
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational - any path leaving state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (drain_idle || timer_expired) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    active   = (state_q != DONE);
    in_drain = (state_q == DRAIN);
    done     = (state_q == DONE);
  end

  // Per-cycle error sources and the resulting counter increments. On timeout,
  // words still queued after this cycle's push/pop each count as one error.
  always_comb begin
    err_flags                = '0;
    err_flags[ERR_MISMATCH]  = pop_ok & ~words_equal;
    err_flags[ERR_UNDERFLOW] = pop_req & fifo_empty;
    err_flags[ERR_OVERFLOW]  = push_req & fifo_full;
    err_flags[ERR_TIMEOUT]   = timer_expired;
    remaining = 32'(fifo_count) + 32'(push_ok) - 32'(pop_ok);
    err_inc   = 32'(err_flags[ERR_MISMATCH]) + 32'(err_flags[ERR_UNDERFLOW])
              + 32'(err_flags[ERR_OVERFLOW])
              + (err_flags[ERR_TIMEOUT] ? remaining : 32'd0);
    match_inc = pop_ok & words_equal;
  end

  // Drain timer: cleared on flush in RUN, counts every DRAIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state_q == RUN && flush) begin
      timer_q <= '0;
    end else if (in_drain) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Saturating match/error counters; increments are zero once DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= '0;
      err_q   <= '0;
    end else begin
      match_q <= CNT_W'(sat_add(32'(match_q), 32'(match_inc), CNT_MAX));
      err_q   <= CNT_W'(sat_add(32'(err_q), err_inc, CNT_MAX));
    end
  end

  // Compare result stage: one-cycle pulse per actual word, expected word
  // reported as zero on underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_match_q <= 1'b0;
      cmp_got_q   <= '0;
      cmp_exp_q   <= '0;
    end else begin
      cmp_valid_q <= pop_req;
      cmp_match_q <= match_inc;
      if (pop_req) begin
        cmp_got_q <= act_data;
        cmp_exp_q <= fifo_empty ? '0 : fifo_head;
      end
    end
  end

  assign exp_full  = fifo_full;
  assign cmp_valid = cmp_valid_q;
  assign cmp_match = cmp_match_q;
  assign cmp_got   = cmp_got_q;
  assign cmp_exp   = cmp_exp_q;
  assign match_cnt = match_q;
  assign err_cnt   = err_q;
  // Counters are frozen in DONE, so this verdict is stable once done rises.
  assign pass      = done & (err_q == '0) & (match_q != '0);

endmodule

// File: tb/tb_stream_checker.sv
// Directed testbench for stream_checker (DEPTH=16, OFFSET=1, TIMEOUT=64), with
// a second CNT_W=2 instance sharing the same stimulus for saturation checks.
module tb_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        exp_valid, act_valid, flush;
  logic [31:0] exp_data, act_data;

  logic        exp_full, cmp_valid, cmp_match, done, pass;
  logic [31:0] cmp_got, cmp_exp;
  logic [15:0] match_cnt, err_cnt;

  logic        exp_full2, cmp_valid2, cmp_match2, done2, pass2;
  logic [31:0] cmp_got2, cmp_exp2;
  logic [1:0]  match_cnt2, err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_checker #(.WIDTH(32), .DEPTH(16), .OFFSET(1), .CNT_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_data(exp_data),
    .act_valid(act_valid), .act_data(act_data), .flush(flush),
    .exp_full(exp_full), .cmp_valid(cmp_valid), .cmp_match(cmp_match),
    .cmp_got(cmp_got), .cmp_exp(cmp_exp), .match_cnt(match_cnt),
    .err_cnt(err_cnt), .done(done), .pass(pass)
  );

  stream_checker #(.WIDTH(32), .DEPTH(16), .OFFSET(1), .CNT_W(2), .TIMEOUT(64)) dut2 (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_data(exp_data),
    .act_valid(act_valid), .act_data(act_data), .flush(flush),
    .exp_full(exp_full2), .cmp_valid(cmp_valid2), .cmp_match(cmp_match2),
    .cmp_got(cmp_got2), .cmp_exp(cmp_exp2), .match_cnt(match_cnt2),
    .err_cnt(err_cnt2), .done(done2), .pass(pass2)
  );

  task automatic idle();
    exp_valid = 1'b0; act_valid = 1'b0; flush = 1'b0;
    exp_data  = '0;   act_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Pulse flush and wait (bounded) for done; returns cycles since the flush edge.
  task automatic flush_and_wait(input int budget, output int cycles);
    flush = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    cycles = 1;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got done=%0b after %0d cycles exp done=1", done, cycles);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({exp_full, cmp_valid, cmp_match, done, pass} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {exp_full, cmp_valid, cmp_match, done, pass});
    end
    checks++;
    if ({cmp_got, cmp_exp, match_cnt, err_cnt} !== 96'b0) begin
      errors++;
      $display("FAIL reset_values got got=%0h exp=%0h m=%0d e=%0d exp all 0",
               cmp_got, cmp_exp, match_cnt, err_cnt);
    end
  endtask

  task automatic test_match_stream();
    int cyc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_valid = (i < 4); exp_data = 32'h10 + 32'(i);
      act_valid = (i >= 1); act_data = 32'h10 + 32'(i);
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if ({cmp_valid, cmp_match} !== 2'b11 || cmp_exp !== 32'h10 + 32'(i)) begin
          errors++;
          $display("FAIL match_cmp%0d got v=%0b m=%0b exp=%0h exp v=1 m=1 exp=%0h",
                   i, cmp_valid, cmp_match, cmp_exp, 32'h10 + 32'(i));
        end
      end
    end
    idle();
    flush_and_wait(20, cyc);
    checks++;
    if (match_cnt !== 16'd4 || err_cnt !== 16'd0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL match_verdict got m=%0d e=%0d pass=%0b exp m=4 e=0 pass=1",
               match_cnt, err_cnt, pass);
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    do_reset();
    exp_valid = 1'b1; exp_data = 32'h10;
    @(negedge clk);
    idle();
    act_valid = 1'b1; act_data = 32'hDEAD_BEEF;
    @(negedge clk);
    idle();
    checks++;
    if ({cmp_valid, cmp_match} !== 2'b10 || cmp_got !== 32'hDEAD_BEEF || cmp_exp !== 32'h11) begin
      errors++;
      $display("FAIL mismatch_cmp got v=%0b m=%0b got=%0h exp=%0h exp v=1 m=0 got=deadbeef exp=11",
               cmp_valid, cmp_match, cmp_got, cmp_exp);
    end
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mismatch_err got %0d exp 1", err_cnt);
    end
    @(negedge clk);
    checks++;
    if (cmp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_pulse got cmp_valid=%0b exp 0", cmp_valid);
    end
    flush_and_wait(20, cyc);
    checks++;
    if (pass !== 1'b0 || match_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mismatch_verdict got pass=%0b m=%0d exp pass=0 m=0", pass, match_cnt);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    act_valid = 1'b1; act_data = 32'h5;
    @(negedge clk);
    idle();
    checks++;
    if ({cmp_valid, cmp_match} !== 2'b10 || cmp_exp !== 32'h0 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL underflow got v=%0b m=%0b exp=%0h e=%0d exp v=1 m=0 exp=0 e=1",
               cmp_valid, cmp_match, cmp_exp, err_cnt);
    end
    exp_valid = 1'b1; exp_data = 32'h20; act_valid = 1'b1; act_data = 32'h21;
    @(negedge clk);
    idle();
    checks++;
    if ({cmp_valid, cmp_match} !== 2'b10 || cmp_exp !== 32'h0 || err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL nobypass got v=%0b m=%0b exp=%0h e=%0d exp v=1 m=0 exp=0 e=2",
               cmp_valid, cmp_match, cmp_exp, err_cnt);
    end
    act_valid = 1'b1; act_data = 32'h21;
    @(negedge clk);
    idle();
    checks++;
    if (cmp_match !== 1'b1 || cmp_exp !== 32'h21 || match_cnt !== 16'd1 || err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL nobypass_stored got m=%0b exp=%0h mc=%0d e=%0d exp m=1 exp=21 mc=1 e=2",
               cmp_match, cmp_exp, match_cnt, err_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp_valid = 1'b1; exp_data = 32'h100 + 32'(i);
      @(negedge clk);
      if (i == 14 || i == 15) begin
        checks++;
        if (exp_full !== (i == 15)) begin
          errors++;
          $display("FAIL full_after_push%0d got %0b exp %0b", i + 1, exp_full, (i == 15));
        end
      end
    end
    idle();
    checks++;
    if (err_cnt !== 16'd1 || exp_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drop got e=%0d full=%0b exp e=1 full=1", err_cnt, exp_full);
    end
    for (int i = 0; i < 16; i++) begin
      act_valid = 1'b1; act_data = 32'h101 + 32'(i);
      @(negedge clk);
      checks++;
      if (cmp_match !== 1'b1 || cmp_got !== 32'h101 + 32'(i)) begin
        errors++;
        $display("FAIL overflow_pop%0d got m=%0b got=%0h exp m=1 got=%0h",
                 i, cmp_match, cmp_got, 32'h101 + 32'(i));
      end
    end
    idle();
    checks++;
    if (match_cnt !== 16'd16 || err_cnt !== 16'd1 || exp_full !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain got m=%0d e=%0d full=%0b exp m=16 e=1 full=0",
               match_cnt, err_cnt, exp_full);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    exp_valid = 1'b1; exp_data = 32'h30;
    @(negedge clk);
    exp_data = 32'h31; act_valid = 1'b1; act_data = 32'h31;
    @(negedge clk);
    exp_data = 32'h32; act_valid = 1'b0;
    @(negedge clk);
    idle();
    flush_and_wait(200, cyc);
    checks++;
    if (cyc !== 65) begin
      errors++;
      $display("FAIL timeout_latency got %0d negedges after flush exp 65", cyc);
    end
    checks++;
    if (err_cnt !== 16'd2 || match_cnt !== 16'd1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL timeout_verdict got e=%0d m=%0d pass=%0b exp e=2 m=1 pass=0",
               err_cnt, match_cnt, pass);
    end
    exp_valid = 1'b1; exp_data = 32'h50; act_valid = 1'b1; act_data = 32'h99; flush = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'd2 || match_cnt !== 16'd1 || done !== 1'b1 || cmp_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_frozen got e=%0d m=%0d done=%0b v=%0b exp e=2 m=1 done=1 v=0",
               err_cnt, match_cnt, done, cmp_valid);
    end
  endtask

  task automatic test_reset_mid_drain_and_saturation();
    int cyc;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_valid = 1'b1; exp_data = 32'h200 + 32'(i);
      @(negedge clk);
    end
    idle();
    act_valid = 1'b1; act_data = 32'h0;
    @(negedge clk);
    idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err_cnt !== 16'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL predrain got e=%0d done=%0b exp e=1 done=0", err_cnt, done);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (err_cnt !== 16'd0 || match_cnt !== 16'd0 || done !== 1'b0 || cmp_got !== 32'h0 ||
        cmp_exp !== 32'h0 || {exp_full2, err_cnt2, done2} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset got e=%0d m=%0d done=%0b got=%0h exp=%0h e2=%0d exp all 0",
               err_cnt, match_cnt, done, cmp_got, cmp_exp, err_cnt2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      exp_valid = (i < 5); exp_data = 32'h40 + 32'(i);
      act_valid = (i >= 1); act_data = 32'h40 + 32'(i);
      @(negedge clk);
    end
    idle();
    flush_and_wait(20, cyc);
    checks++;
    if (match_cnt !== 16'd5 || err_cnt !== 16'd0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_run got m=%0d e=%0d pass=%0b exp m=5 e=0 pass=1",
               match_cnt, err_cnt, pass);
    end
    checks++;
    if (match_cnt2 !== 2'd3 || err_cnt2 !== 2'd0 || pass2 !== 1'b1 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL saturate_cnt2 got m=%0d e=%0d pass=%0b done=%0b exp m=3 e=0 pass=1 done=1",
               match_cnt2, err_cnt2, pass2, done2);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_match_stream();
    test_mismatch();
    test_underflow();
    test_overflow();
    test_timeout();
    test_reset_mid_drain_and_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
